calc_alu_sequencer: RTL and testbench
=====================================

Name: calc_alu_sequencer

Overview:
- Multi-cycle arithmetic engine for the calculator FSM.
- Takes one operation request: two signed decimal fixed-point operands (value × SCALE, e.g. 5.25 = 525) and an op code.
- Runs ADD/SUB in one compute step. Runs MUL/DIV on a shared shift-add multiplier and restoring divider.
- Returns a saturated result over a valid/ready handshake. Sits between the button-decode FSM and the result/seven-segment path.

Parameters:
- DW, 16, operand/result width (signed two's complement).
- SCALE, 100, fixed-point decimal scale factor.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  synchronous active-low reset.
- abort  in  1  synchronous cancel (driven by clear button).
- req_valid  in  1  request present.
- req_ready  out  1  request accepted when req_valid && req_ready at an edge.
- req_op  in  3  0=ADD, 1=SUB, 2=MUL, 3=DIV, 4..7=PASS.
- req_a  in  DW  operand A (left).
- req_b  in  DW  operand B (right).
- rsp_valid  out  1  result available.
- rsp_ready  in  1  consumer takes result when rsp_valid && rsp_ready at an edge.
- result  out  DW  signed scaled result.
- overflow  out  1  result saturated.
- div_zero  out  1  DIV with B=0.
- busy  out  1  state != IDLE.

Behaviour:
- Reset (rst_n=0 at edge): state=IDLE; rsp_valid=0, result=0, overflow=0, div_zero=0, busy=0. Internal registers cleared. Reset overrides everything, including mid-operation.
- req_ready = (state==IDLE) && !abort, combinational. All other outputs are registered.
- States: IDLE, MUL, DIV, FIN, DONE.
- Accept edge, IDLE exits:
  - Latch sign = sign(A) XOR sign(B) for MUL/DIV; latch |A|, |B| as unsigned DW bits.
  - ADD/SUB: compute A±B in DW+1 bits → FIN.
  - MUL: → MUL (DW cycles), shift-add |A|×|B| into 2·DW-bit product.
  - DIV with B≠0: dividend = |A|×SCALE (2·DW bits) → DIV.
  - DIV with B=0: → DONE directly with div_zero=1, overflow=0, result = +max (2^(DW-1)-1) if A≥0, else -2^(DW-1).
  - PASS: → DONE with result=A, flags 0.
- MUL exit: → DIV with dividend = product, divisor = SCALE.
- DIV: restoring divider, 2·DW iterations, one quotient bit per cycle, remainder DW+1 bits → FIN.
- FIN (one cycle):
  - Apply sign to quotient or sum; truncate toward zero.
  - Saturate to [-2^(DW-1), 2^(DW-1)-1]; overflow=1 if clipped. Magnitude exactly 2^(DW-1) with negative sign is legal, no overflow.
  - → DONE.
- DONE: rsp_valid=1. result and flags are held stable until the rsp_ready edge, then → IDLE and rsp_valid=0. The next request can be accepted on the following edge, not the same one.
- Latency, accept edge to first cycle rsp_valid=1 (edges counted including the accept edge):
  - ADD/SUB: 2.
  - MUL: 3·DW+2 = 50.
  - DIV: 2·DW+2 = 34.
  - DIV-by-zero and PASS: 1.
- abort=1 at any edge (rst_n=1):
  - → IDLE; rsp_valid=0, busy=0.
  - result and flags keep their last values.
  - A simultaneous req_valid is not accepted; abort wins.
- Flags are cleared at every accept edge.
- req_* is ignored while not IDLE; operands are latched and need not be held after acceptance.

Optional Feature:
- Macro CALC_ROUND_EN.
- Defined: FIN rounds half away from zero. Applies to DIV outputs, including the MUL ÷ SCALE pass: add 1 to the magnitude when 2×remainder ≥ divisor, before sign/saturation. Latency unchanged.
- Undefined: truncate toward zero. ADD/SUB/PASS are unaffected either way.

Test Plan:
- Reset, then ADD A=525, B=300 → rsp_valid on 2nd edge after accept, result=825, flags 0. Hold rsp_ready=0 for 5 cycles → result stable; release → IDLE, req_ready=1.
- SUB A=-525, B=300 → -825. ADD A=30000, B=30000 → 32767, overflow=1. SUB A=-32768, B=1 → -32768, overflow=1.
- DIV A=600, B=300 → 200 after 34 edges. DIV A=200, B=300 → 66 (macro off) or 67 (CALC_ROUND_EN). DIV A=-500, B=0 → -32768, div_zero=1, latency 1.
- MUL A=200, B=800 → 1600 (16.00) after 50 edges. MUL A=-150, B=250 → -375. MUL A=30000, B=30000 → 32767, overflow=1.
- Abort at cycle 20 of a MUL with req_valid=1 on the same edge → IDLE, no rsp_valid, request not taken. Next ADD A=100, B=100 → 200 normally.
- rst_n=0 mid-DIV → all outputs at reset values next cycle. PASS A=-123 → -123, latency 1.

Source files
------------

// File: rtl/calc_alu_sequencer.sv
// Multi-cycle fixed-point ALU: one-step ADD/SUB, shift-add MUL and restoring DIV, saturated result.
// Optional: define CALC_ROUND_EN to round divider outputs half away from zero instead of truncating.
module calc_alu_sequencer #(
  parameter int DW    = 16,
  parameter int SCALE = 100
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          abort,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [2:0]    req_op,
  input  logic [DW-1:0] req_a,
  input  logic [DW-1:0] req_b,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [DW-1:0] result,
  output logic          overflow,
  output logic          div_zero,
  output logic          busy
);

  localparam int PW = 2 * DW;
  localparam int CW = $clog2(PW);

  localparam logic [DW-1:0] RES_MAX = {1'b0, {(DW-1){1'b1}}};
  localparam logic [DW-1:0] RES_MIN = {1'b1, {(DW-1){1'b0}}};
  localparam logic [PW:0]   MAG_POS = (PW+1)'(2**(DW-1) - 1);
  localparam logic [PW:0]   MAG_NEG = (PW+1)'(2**(DW-1));

  typedef enum logic [2:0] {S_IDLE, S_MUL, S_DIV, S_FIN, S_DONE} state_e;

  state_e        state_q;
  logic          sign_q, sum_path_q;
  logic [PW-1:0] mcand_q, prod_q, dvd_q;
  logic [DW-1:0] mplier_q, dvs_q, rem_q;
  logic [DW:0]   sum_q;
  logic [CW-1:0] cnt_q;
  logic [DW-1:0] result_q;
  logic          ovf_q, dz_q, rsp_valid_q;

  assign req_ready = (state_q == S_IDLE) && !abort;
  assign busy      = (state_q != S_IDLE);
  assign rsp_valid = rsp_valid_q;
  assign result    = result_q;
  assign overflow  = ovf_q;
  assign div_zero  = dz_q;

  // Operand magnitudes; -2^(DW-1) maps to 2^(DW-1), which still fits unsigned DW bits.
  logic          a_neg, b_neg;
  logic [DW-1:0] a_mag, b_mag;
  assign a_neg = req_a[DW-1];
  assign b_neg = req_b[DW-1];
  assign a_mag = a_neg ? -req_a : req_a;
  assign b_mag = b_neg ? -req_b : req_b;

  // One multiplier step and one restoring-divider step per cycle.
  logic [PW-1:0] prod_d, dvd_d;
  logic [DW:0]   rem_sh;
  logic          rem_ge;
  logic [DW-1:0] rem_d;
  assign prod_d = prod_q + (mplier_q[0] ? mcand_q : '0);
  assign rem_sh = {rem_q, dvd_q[PW-1]};
  assign rem_ge = rem_sh >= {1'b0, dvs_q};
  assign rem_d  = rem_ge ? DW'(rem_sh - {1'b0, dvs_q}) : rem_sh[DW-1:0];
  assign dvd_d  = {dvd_q[PW-2:0], rem_ge};

  logic          round_inc;
  logic [PW:0]   mag;
  logic [DW-1:0] fin_res;
  logic          fin_ovf;

  // NOTE: every signal assigned here gets a default first so no latch can be inferred.
  always_comb begin
    round_inc = 1'b0;
`ifdef CALC_ROUND_EN
    round_inc = {rem_q, 1'b0} >= {1'b0, dvs_q};
`endif
    mag     = {1'b0, dvd_q} + (PW+1)'(round_inc);
    fin_res = '0;
    fin_ovf = 1'b0;
    if (sum_path_q) begin
      if (sum_q[DW] != sum_q[DW-1]) begin
        fin_res = sum_q[DW] ? RES_MIN : RES_MAX;
        fin_ovf = 1'b1;
      end else begin
        fin_res = sum_q[DW-1:0];
      end
    end else if (sign_q) begin
      if (mag > MAG_NEG) begin
        fin_res = RES_MIN;
        fin_ovf = 1'b1;
      end else begin
        fin_res = -mag[DW-1:0];
      end
    end else if (mag > MAG_POS) begin
      fin_res = RES_MAX;
      fin_ovf = 1'b1;
    end else begin
      fin_res = mag[DW-1:0];
    end
  end

  // NOTE: all state here uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      sign_q      <= 1'b0;
      sum_path_q  <= 1'b0;
      mcand_q     <= '0;
      prod_q      <= '0;
      dvd_q       <= '0;
      mplier_q    <= '0;
      dvs_q       <= '0;
      rem_q       <= '0;
      sum_q       <= '0;
      cnt_q       <= '0;
      result_q    <= '0;
      ovf_q       <= 1'b0;
      dz_q        <= 1'b0;
      rsp_valid_q <= 1'b0;
    end else if (abort) begin
      state_q     <= S_IDLE;
      rsp_valid_q <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: if (req_valid) begin
          ovf_q      <= 1'b0;
          dz_q       <= 1'b0;
          sign_q     <= a_neg ^ b_neg;
          sum_path_q <= 1'b0;
          cnt_q      <= '0;
          rem_q      <= '0;
          unique case (req_op)
            3'd0, 3'd1: begin
              sum_q      <= (req_op == 3'd0) ? {a_neg, req_a} + {b_neg, req_b}
                                             : {a_neg, req_a} - {b_neg, req_b};
              sum_path_q <= 1'b1;
              state_q    <= S_FIN;
            end
            3'd2: begin
              mcand_q  <= PW'(a_mag);
              mplier_q <= b_mag;
              prod_q   <= '0;
              state_q  <= S_MUL;
            end
            3'd3: begin
              if (req_b == '0) begin
                dz_q        <= 1'b1;
                result_q    <= a_neg ? RES_MIN : RES_MAX;
                rsp_valid_q <= 1'b1;
                state_q     <= S_DONE;
              end else begin
                dvd_q   <= PW'(a_mag) * PW'(SCALE);
                dvs_q   <= b_mag;
                state_q <= S_DIV;
              end
            end
            default: begin
              result_q    <= req_a;
              rsp_valid_q <= 1'b1;
              state_q     <= S_DONE;
            end
          endcase
        end
        S_MUL: begin
          prod_q   <= prod_d;
          mcand_q  <= {mcand_q[PW-2:0], 1'b0};
          mplier_q <= {1'b0, mplier_q[DW-1:1]};
          cnt_q    <= cnt_q + 1'b1;
          if (cnt_q == CW'(DW - 1)) begin
            dvd_q   <= prod_d;
            dvs_q   <= DW'(SCALE);
            cnt_q   <= '0;
            state_q <= S_DIV;
          end
        end
        S_DIV: begin
          dvd_q <= dvd_d;
          rem_q <= rem_d;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CW'(PW - 1)) begin
            cnt_q   <= '0;
            state_q <= S_FIN;
          end
        end
        S_FIN: begin
          result_q    <= fin_res;
          ovf_q       <= fin_ovf;
          rsp_valid_q <= 1'b1;
          state_q     <= S_DONE;
        end
        S_DONE: if (rsp_ready) begin
          rsp_valid_q <= 1'b0;
          state_q     <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_calc_alu_sequencer.sv
// Directed bench for calc_alu_sequencer: hand-computed results, flags and latencies.
module tb_calc_alu_sequencer;

  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst_n, abort, req_valid, req_ready, rsp_valid, rsp_ready;
  logic          overflow, div_zero, busy;
  logic [2:0]    req_op;
  logic [DW-1:0] req_a, req_b, result;

  int n_vec = 0;
  int n_err = 0;
  int lat;

`ifdef CALC_ROUND_EN
  localparam int DIV_200_300 = 67;
`else
  localparam int DIV_200_300 = 66;
`endif

  calc_alu_sequencer #(.DW(DW), .SCALE(100)) dut (
    .clk(clk), .rst_n(rst_n), .abort(abort),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .result(result), .overflow(overflow), .div_zero(div_zero), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Present a request at a negedge; lat counts edges from accept to first rsp_valid=1.
  task automatic run_req(input logic [2:0] op, input int a, input int b, output int l);
    @(negedge clk);
    req_op    = op;
    req_a     = DW'(a);
    req_b     = DW'(b);
    req_valid = 1'b1;
    #1 check("req_ready_idle", req_ready, 1);
    @(posedge clk);
    #1 req_valid = 1'b0;
    req_a = 16'h5a5a;
    req_b = 16'ha5a5;
    l = 1;
    @(negedge clk);
    while (rsp_valid !== 1'b1 && l < 200) begin
      @(negedge clk);
      l++;
    end
  endtask

  task automatic consume();
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check("rsp_valid_after_take", rsp_valid, 0);
    check("busy_after_take", busy, 0);
    check("req_ready_after_take", req_ready, 1);
  endtask

  task automatic do_op(input string tag, input logic [2:0] op, input int a, input int b,
                       input int exp_res, input int exp_ovf, input int exp_dz, input int exp_lat);
    int l;
    run_req(op, a, b, l);
    check({tag, "_lat"}, l, exp_lat);
    check({tag, "_res"}, $signed(result), exp_res);
    check({tag, "_ovf"}, overflow, exp_ovf);
    check({tag, "_dz"}, div_zero, exp_dz);
    consume();
  endtask

  initial begin
    rst_n = 1'b0; abort = 1'b0; req_valid = 1'b0; rsp_ready = 1'b0;
    req_op = 3'd0; req_a = '0; req_b = '0;
    repeat (2) @(negedge clk);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_result", $signed(result), 0);
    check("rst_ovf", overflow, 0);
    check("rst_dz", div_zero, 0);
    check("rst_busy", busy, 0);
    rst_n = 1'b1;

    // ADD with the consumer stalling for five cycles
    run_req(3'd0, 525, 300, lat);
    check("add_lat", lat, 2);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("hold_result", $signed(result), 825);
      check("hold_valid", rsp_valid, 1);
    end
    consume();

    do_op("sub",      3'd1, -525,   300,   -825,   0, 0, 2);
    do_op("add_sat",  3'd0, 30000,  30000, 32767,  1, 0, 2);
    do_op("sub_sat",  3'd1, -32768, 1,     -32768, 1, 0, 2);
    do_op("div",      3'd3, 600,    300,   200,    0, 0, 34);
    do_op("div_frac", 3'd3, 200,    300,   DIV_200_300, 0, 0, 34);
    do_op("div_zero", 3'd3, -500,   0,     -32768, 0, 1, 1);
    do_op("mul",      3'd2, 200,    800,   1600,   0, 0, 50);
    do_op("mul_neg",  3'd2, -150,   250,   -375,   0, 0, 50);
    do_op("mul_sat",  3'd2, 30000,  30000, 32767,  1, 0, 50);

    // Abort partway through a MUL, with a competing request on the same edge
    @(negedge clk);
    req_op = 3'd2; req_a = 16'd200; req_b = 16'd800; req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    repeat (19) @(negedge clk);
    abort = 1'b1; req_valid = 1'b1; req_op = 3'd0; req_a = 16'd1; req_b = 16'd1;
    #1 check("abort_req_ready", req_ready, 0);
    check("abort_busy_before", busy, 1);
    @(negedge clk);
    abort = 1'b0; req_valid = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_rsp_valid", rsp_valid, 0);
    check("abort_result_kept", $signed(result), 32767);
    check("abort_flags_cleared", overflow, 0);
    repeat (3) @(negedge clk);
    check("abort_not_taken_valid", rsp_valid, 0);
    check("abort_not_taken_busy", busy, 0);

    do_op("add_after_abort", 3'd0, 100, 100, 200, 0, 0, 2);

    // Reset in the middle of a DIV
    @(negedge clk);
    req_op = 3'd3; req_a = 16'd600; req_b = 16'd300; req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    repeat (10) @(negedge clk);
    check("mid_div_busy", busy, 1);
    rst_n = 1'b0;
    @(negedge clk);
    check("mid_rst_result", $signed(result), 0);
    check("mid_rst_valid", rsp_valid, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_ovf", overflow, 0);
    check("mid_rst_dz", div_zero, 0);
    rst_n = 1'b1;

    do_op("pass", 3'd5, -123, 777, -123, 0, 0, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
